// File: rtl/dma_hold_responder.sv
// CPU-side responder for the DMA hold handshake: stall the CPU, float its bus,
// then grant HLDA; release on HRQ drop or when the hold-time limit expires.
module dma_hold_responder #(
    parameter int FLOAT_DLY  = 1,
    parameter int TURN_DLY   = 1,
    parameter int HOLD_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HRQ,
    input  logic        cpu_busy,
    input  logic        AEN,
    input  logic        TC,
    output logic        HLDA,
    output logic        BUS_FLOAT,
    output logic        CPU_STALL,
    output logic [7:0]  grant_count,
    output logic [15:0] hold_cycles,
    output logic        timeout_flag,
    output logic        tc_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CYC,
        S_FLOAT,
        S_GRANT,
        S_RELEASE,
        S_LOCKOUT
    } state_t;

    localparam logic [2:0]  FLOAT_LOAD = 3'(FLOAT_DLY);
    localparam logic [2:0]  TURN_LOAD  = 3'(TURN_DLY);
    localparam logic        LIMIT_EN   = (HOLD_LIMIT != 0);
    localparam logic [15:0] LIMIT_LAST = 16'(HOLD_LIMIT - 1);

    state_t     state, state_nxt;
    logic [2:0] dly_cnt, dly_cnt_nxt;
    logic       to_pend, to_pend_nxt;
    logic       hrq_meta, hrq_s;
    logic       grant_entry, grant_done, timeout_evt;

    // AEN is a debug-only observation; it has no functional effect here.
    logic unused_aen;
    assign unused_aen = AEN;

    // NOTE: non-blocking assignments make hrq_s take the previous hrq_meta,
    // giving a real two-stage synchronizer instead of a single wire-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hrq_meta <= 1'b0;
            hrq_s    <= 1'b0;
        end else begin
            hrq_meta <= HRQ;
            hrq_s    <= hrq_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            dly_cnt <= 3'd0;
            to_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_cnt_nxt;
            to_pend <= to_pend_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        dly_cnt_nxt = dly_cnt;
        to_pend_nxt = to_pend;
        grant_entry = 1'b0;
        grant_done  = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            S_IDLE: begin
                if (hrq_s) state_nxt = S_WAIT_CYC;
            end
            S_WAIT_CYC: begin
                if (!hrq_s) begin
                    state_nxt = S_IDLE;
                end else if (!cpu_busy) begin
                    state_nxt   = S_FLOAT;
                    dly_cnt_nxt = FLOAT_LOAD;
                end
            end
            S_FLOAT: begin
                if (!hrq_s) begin
                    state_nxt   = S_RELEASE;
                    dly_cnt_nxt = TURN_LOAD;
                    to_pend_nxt = 1'b0;
                end else if (dly_cnt <= 3'd1) begin
                    state_nxt   = S_GRANT;
                    dly_cnt_nxt = 3'd0;
                    grant_entry = 1'b1;
                end else begin
                    dly_cnt_nxt = dly_cnt - 3'd1;
                end
            end
            S_GRANT: begin
                // A requester drop wins over a coincident timeout.
                if (!hrq_s) begin
                    state_nxt   = S_RELEASE;
                    dly_cnt_nxt = TURN_LOAD;
                    to_pend_nxt = 1'b0;
                    grant_done  = 1'b1;
                end else if (LIMIT_EN && hold_cycles == LIMIT_LAST) begin
                    state_nxt   = S_RELEASE;
                    dly_cnt_nxt = TURN_LOAD;
                    to_pend_nxt = 1'b1;
                    grant_done  = 1'b1;
                    timeout_evt = 1'b1;
                end
            end
            S_RELEASE: begin
                if (dly_cnt <= 3'd1) begin
                    state_nxt   = to_pend ? S_LOCKOUT : S_IDLE;
                    dly_cnt_nxt = 3'd0;
                    to_pend_nxt = 1'b0;
                end else begin
                    dly_cnt_nxt = dly_cnt - 3'd1;
                end
            end
            S_LOCKOUT: begin
                if (!hrq_s) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt   = S_IDLE;
                dly_cnt_nxt = 3'd0;
                to_pend_nxt = 1'b0;
            end
        endcase
    end

    // Handshake outputs decode straight from state so reset drops them at once.
    always_comb begin
        HLDA      = (state == S_GRANT);
        BUS_FLOAT = (state == S_FLOAT) || (state == S_GRANT) || (state == S_RELEASE);
        CPU_STALL = (state == S_WAIT_CYC) || BUS_FLOAT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count  <= 8'd0;
            hold_cycles  <= 16'd0;
            timeout_flag <= 1'b0;
            tc_seen      <= 1'b0;
        end else begin
            if (grant_entry)
                hold_cycles <= 16'd0;
            else if (state == S_GRANT && hold_cycles != 16'hFFFF)
                hold_cycles <= hold_cycles + 16'd1;
            if (grant_done)
                grant_count <= grant_count + 8'd1;
            if (timeout_evt)
                timeout_flag <= 1'b1;
            if (state == S_GRANT && TC)
                tc_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_hold_responder.sv
// Self-checking bench for dma_hold_responder: per-cycle vector table with a
// scoreboard queue, plus hand sequences for async reset and counter wrap.
module tb_dma_hold_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        HRQ, cpu_busy, AEN, TC;
    logic        HLDA, BUS_FLOAT, CPU_STALL;
    logic [7:0]  grant_count;
    logic [15:0] hold_cycles;
    logic        timeout_flag, tc_seen;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       hrq;
        logic       busy;
        logic       tc;
        logic [2:0] exp;   // {HLDA, BUS_FLOAT, CPU_STALL} after the edge
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];
    int         mark[6];

    dma_hold_responder #(
        .FLOAT_DLY (1),
        .TURN_DLY  (1),
        .HOLD_LIMIT(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .HRQ         (HRQ),
        .cpu_busy    (cpu_busy),
        .AEN         (AEN),
        .TC          (TC),
        .HLDA        (HLDA),
        .BUS_FLOAT   (BUS_FLOAT),
        .CPU_STALL   (CPU_STALL),
        .grant_count (grant_count),
        .hold_cycles (hold_cycles),
        .timeout_flag(timeout_flag),
        .tc_seen     (tc_seen)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_status(input string tag, input int gc, input int hold,
                                input logic tf, input logic tcs);
        check({tag, "_grant_count"}, 32'(grant_count), 32'(gc));
        check({tag, "_hold_cycles"}, 32'(hold_cycles), 32'(hold));
        check({tag, "_timeout_flag"}, 32'(timeout_flag), 32'(tf));
        check({tag, "_tc_seen"}, 32'(tc_seen), 32'(tcs));
    endtask

    task automatic vec(input logic hrq, input logic busy, input logic tc,
                       input logic [2:0] exp, input int n);
        vec_t v;
        v.hrq  = hrq;
        v.busy = busy;
        v.tc   = tc;
        v.exp  = exp;
        repeat (n) vecs.push_back(v);
    endtask

    // Called at a negedge: drive one row, push its expectation, pop after the edge.
    task automatic run_vecs(input int first, input int last);
        logic [2:0] exp;
        for (int i = first; i < last; i++) begin
            HRQ      = vecs[i].hrq;
            cpu_busy = vecs[i].busy;
            TC       = vecs[i].tc;
            AEN      = 1'($urandom_range(0, 1));
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check($sformatf("row%0d_scoreboard_empty", i), 32'd1, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                check($sformatf("row%0d_hlda_float_stall", i),
                      32'({HLDA, BUS_FLOAT, CPU_STALL}), 32'(exp));
            end
        end
    endtask

    task automatic do_grant(input string tag);
        int n;
        HRQ = 1'b1;
        cpu_busy = 1'b0;
        n = 0;
        while (HLDA !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_hlda_up"}, 32'(HLDA), 32'd1);
        HRQ = 1'b0;
        n = 0;
        while ((BUS_FLOAT !== 1'b0 || CPU_STALL !== 1'b0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bus_back"}, 32'({HLDA, BUS_FLOAT, CPU_STALL}), 32'd0);
    endtask

    initial begin
        int n;
        HRQ = 1'b0; cpu_busy = 1'b0; AEN = 1'b0; TC = 1'b0;

        // Basic grant; TC in IDLE and in RELEASE must not be recorded.
        vec(1, 0, 1, 3'b000, 1);
        vec(1, 0, 0, 3'b000, 1);
        vec(1, 0, 0, 3'b001, 1);
        vec(1, 0, 0, 3'b011, 1);
        vec(1, 0, 0, 3'b111, 1);
        vec(0, 0, 0, 3'b111, 2);
        vec(0, 0, 0, 3'b011, 1);
        vec(0, 0, 1, 3'b000, 1);
        vec(0, 0, 0, 3'b000, 1);
        mark[0] = vecs.size();
        // cpu_busy holds off the float; TC during GRANT.
        vec(1, 1, 0, 3'b000, 2);
        vec(1, 1, 0, 3'b001, 4);
        vec(1, 0, 0, 3'b011, 1);
        vec(1, 0, 0, 3'b111, 1);
        vec(0, 0, 1, 3'b111, 1);
        vec(0, 0, 0, 3'b111, 1);
        vec(0, 0, 0, 3'b011, 1);
        vec(0, 0, 0, 3'b000, 1);
        mark[1] = vecs.size();
        // HRQ drops during FLOAT, then HRQ drops during WAIT_CYC.
        vec(1, 1, 0, 3'b000, 2);
        vec(1, 1, 0, 3'b001, 2);
        vec(0, 1, 0, 3'b001, 1);
        vec(0, 0, 0, 3'b011, 2);
        vec(0, 0, 0, 3'b000, 2);
        vec(1, 1, 0, 3'b000, 2);
        vec(0, 1, 0, 3'b001, 2);
        vec(0, 1, 0, 3'b000, 2);
        mark[2] = vecs.size();
        // Hold-limit timeout with HRQ stuck high, lockout, then HRQ low.
        vec(1, 0, 0, 3'b000, 2);
        vec(1, 0, 0, 3'b001, 1);
        vec(1, 0, 0, 3'b011, 1);
        vec(1, 0, 0, 3'b111, 8);
        vec(1, 0, 0, 3'b011, 1);
        vec(1, 0, 0, 3'b000, 3);
        vec(0, 0, 0, 3'b000, 3);
        mark[3] = vecs.size();
        // Regrant after lockout clears.
        vec(1, 0, 0, 3'b000, 2);
        vec(1, 0, 0, 3'b001, 1);
        vec(1, 0, 0, 3'b011, 1);
        vec(1, 0, 0, 3'b111, 1);
        vec(0, 0, 0, 3'b111, 2);
        vec(0, 0, 0, 3'b011, 1);
        vec(0, 0, 0, 3'b000, 1);
        mark[4] = vecs.size();
        // hrq_s falls on the same cycle the limit is reached: normal release.
        vec(1, 0, 0, 3'b000, 2);
        vec(1, 0, 0, 3'b001, 1);
        vec(1, 0, 0, 3'b011, 1);
        vec(1, 0, 0, 3'b111, 6);
        vec(0, 0, 0, 3'b111, 2);
        vec(0, 0, 0, 3'b011, 1);
        vec(0, 0, 0, 3'b000, 2);
        mark[5] = vecs.size();

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hlda_float_stall", 32'({HLDA, BUS_FLOAT, CPU_STALL}), 32'd0);
        check_status("reset", 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run_vecs(0, mark[0]);
        check_status("basic", 1, 3, 1'b0, 1'b0);
        run_vecs(mark[0], mark[1]);
        check_status("busy", 2, 3, 1'b0, 1'b1);
        run_vecs(mark[1], mark[2]);
        check_status("abort", 2, 3, 1'b0, 1'b1);
        run_vecs(mark[2], mark[3]);
        check_status("timeout", 3, 8, 1'b1, 1'b1);
        run_vecs(mark[3], mark[4]);
        check_status("regrant", 4, 3, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a grant, between clock edges.
        HRQ = 1'b1; cpu_busy = 1'b0; TC = 1'b0;
        n = 0;
        while (HLDA !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midgrant_hlda_up", 32'(HLDA), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midgrant_async_drop", 32'({HLDA, BUS_FLOAT, CPU_STALL}), 32'd0);
        check_status("midgrant", 0, 0, 1'b0, 1'b0);
        HRQ = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_vecs(mark[4], mark[5]);
        check_status("coincident", 1, 8, 1'b0, 1'b0);

        for (int g = 0; g < 254; g++) do_grant("wrap");
        check("wrap_count_255", 32'(grant_count), 32'd255);
        do_grant("wrap_last");
        check("wrap_count_0", 32'(grant_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
